// File: rtl/com_mul_seq_if.sv
// rtl/com_mul_seq_if.sv - operand/result handshake and multiplier-side bus for com_mul_seq
interface com_mul_seq_if #(parameter int width = 16);
  logic             s_valid;
  logic             s_ready;
  logic [width-1:0] s_a, s_a_i, s_b, s_b_i;
  logic [4:0]       s_mbit1, s_mbit2;
  logic [width-1:0] mul_a, mul_a_i, mul_b, mul_b_i;
  logic [4:0]       mul_mbit1, mul_mbit2;
  logic             mul_flag;
  logic [width-1:0] mul_re, mul_im;
  logic             mul_over;
  logic             m_valid;
  logic             m_ready;
  logic [width-1:0] m_re, m_im;
  logic             m_err;
  logic [15:0]      op_count;

  // Sequencer side
  modport slave (
    input  s_valid, s_a, s_a_i, s_b, s_b_i, s_mbit1, s_mbit2,
    output s_ready,
    output mul_a, mul_a_i, mul_b, mul_b_i, mul_mbit1, mul_mbit2, mul_flag,
    input  mul_re, mul_im, mul_over,
    output m_valid, m_re, m_im, m_err, op_count,
    input  m_ready
  );

  // Environment side: operand source, multiplier and result sink
  modport master (
    output s_valid, s_a, s_a_i, s_b, s_b_i, s_mbit1, s_mbit2,
    input  s_ready,
    input  mul_a, mul_a_i, mul_b, mul_b_i, mul_mbit1, mul_mbit2, mul_flag,
    output mul_re, mul_im, mul_over,
    input  m_valid, m_re, m_im, m_err, op_count,
    output m_ready
  );
endinterface

// File: rtl/com_mul_seq.sv
// rtl/com_mul_seq.sv - operand sequencer for the complex EFP multiplier with zero bypass and timeout
// Optional completed-operation counter enabled by COM_MUL_SEQ_STATS_EN.
module com_mul_seq #(
  parameter int width   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst,
  com_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, OUT, GAP} state_t;

  state_t           state, state_nx;
  logic             started;
  logic [7:0]       tmo_cnt;
  logic [width-1:0] mul_a_q, mul_a_i_q, mul_b_q, mul_b_i_q;
  logic [4:0]       mbit1_q, mbit2_q;
  logic [width-1:0] m_re_q, m_im_q;
  logic             m_err_q;

  logic s_ready_c, flag_c, valid_c;
  logic load_op, zero_op, cap, abort;
  logic zero_in, tmo_hit;

  // The multiplier never raises over when either operand is complex zero
  assign zero_in = ((bus.s_a == '0) && (bus.s_a_i == '0)) ||
                   ((bus.s_b == '0) && (bus.s_b_i == '0));
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready_c = 1'b0;
    flag_c    = 1'b0;
    valid_c   = 1'b0;
    load_op   = 1'b0;
    zero_op   = 1'b0;
    cap       = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        s_ready_c = started;
        if (bus.s_valid && started) begin
          load_op  = 1'b1;
          zero_op  = zero_in;
          state_nx = zero_in ? OUT : RUN;
        end
      end
      RUN: begin
        flag_c = 1'b1;
        if (bus.mul_over) begin
          cap      = 1'b1;
          state_nx = OUT;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = OUT;
        end
      end
      OUT: begin
        valid_c = 1'b1;
        if (bus.m_ready) state_nx = GAP;
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      tmo_cnt   <= '0;
      mul_a_q   <= '0;
      mul_a_i_q <= '0;
      mul_b_q   <= '0;
      mul_b_i_q <= '0;
      mbit1_q   <= '0;
      mbit2_q   <= '0;
      m_re_q    <= '0;
      m_im_q    <= '0;
      m_err_q   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (load_op) begin
        mul_a_q   <= bus.s_a;
        mul_a_i_q <= bus.s_a_i;
        mul_b_q   <= bus.s_b;
        mul_b_i_q <= bus.s_b_i;
        mbit1_q   <= bus.s_mbit1;
        mbit2_q   <= bus.s_mbit2;
        tmo_cnt   <= '0;
      end else if (state == RUN) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (zero_op || abort) begin
        m_re_q  <= '0;
        m_im_q  <= '0;
        m_err_q <= abort;
      end else if (cap) begin
        m_re_q  <= bus.mul_re;
        m_im_q  <= bus.mul_im;
        m_err_q <= 1'b0;
      end
    end
  end

`ifdef COM_MUL_SEQ_STATS_EN
  logic [15:0] op_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  op_cnt <= '0;
    else if (valid_c && bus.m_ready && !m_err_q) op_cnt <= op_cnt + 16'd1;
  end
  assign bus.op_count = op_cnt;
`else
  assign bus.op_count = '0;
`endif

  assign bus.s_ready   = s_ready_c;
  assign bus.mul_flag  = flag_c;
  assign bus.m_valid   = valid_c;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_a_i   = mul_a_i_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_b_i   = mul_b_i_q;
  assign bus.mul_mbit1 = mbit1_q;
  assign bus.mul_mbit2 = mbit2_q;
  assign bus.m_re      = m_re_q;
  assign bus.m_im      = m_im_q;
  assign bus.m_err     = m_err_q;

endmodule

// File: tb/tb_com_mul_seq.sv
// tb/tb_com_mul_seq.sv - directed self-checking bench for com_mul_seq with a mock multiplier
module tb_com_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  com_mul_seq_if #(.width(16)) bus ();

  com_mul_seq #(.width(16), .TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Mock multiplier: over asserted in the 5th flag-high cycle
  logic       mock_en   = 1'b1;
  logic       mock_mode = 1'b0;
  logic [7:0] mock_cnt  = '0;
  always @(posedge clk) mock_cnt <= bus.mul_flag ? mock_cnt + 8'd1 : 8'd0;
  assign bus.mul_over = mock_en && bus.mul_flag && (mock_cnt == 8'd4);
  assign bus.mul_re   = mock_mode ? bus.mul_a + bus.mul_b     : 16'h1234;
  assign bus.mul_im   = mock_mode ? bus.mul_a_i + bus.mul_b_i : 16'h5678;

  logic [15:0] va  [4] = '{16'h0100, 16'h1000, 16'h0000, 16'h4000};
  logic [15:0] vai [4] = '{16'h0000, 16'h0010, 16'h0000, 16'h0100};
  logic [15:0] vb  [4] = '{16'h0200, 16'h0001, 16'h3C00, 16'h0400};
  logic [15:0] vbi [4] = '{16'h0001, 16'h0002, 16'h0000, 16'h0020};
  logic [32:0] vexp[4] = '{{16'h0300, 16'h0001, 1'b0}, {16'h1001, 16'h0012, 1'b0},
                           {16'h0000, 16'h0000, 1'b0}, {16'h4400, 16'h0120, 1'b0}};

  // Called at a negedge; returns at the negedge where m_valid was seen (mr=0)
  // or the negedge after the result handshake (mr=1).
  task automatic do_op(input logic [15:0] a, ai, b, bi, input logic mr,
                       output logic [15:0] re, im, output logic err,
                       output int flag_cyc, output int lat);
    int w;
    bus.s_a = a; bus.s_a_i = ai; bus.s_b = b; bus.s_b_i = bi;
    bus.s_mbit1 = 5'd3; bus.s_mbit2 = 5'd4;
    bus.s_valid = 1'b1;
    bus.m_ready = mr;
    w = 0;
    while (!bus.s_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.s_ready) begin
      errors++; checks++;
      $display("FAIL accept_wait: s_ready=%b after %0d cycles, required 1", bus.s_ready, w);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    lat = 1; flag_cyc = 0;
    while (!bus.m_valid && lat < 100) begin
      if (bus.mul_flag) flag_cyc++;
      @(negedge clk);
      lat++;
    end
    re = bus.m_re; im = bus.m_im; err = bus.m_err;
    if (mr) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bus.m_valid); end
    checks++; if (bus.mul_flag !== 1'b0) begin errors++; $display("FAIL rst_mul_flag: got %b want 0", bus.mul_flag); end
    checks++; if ({bus.m_re, bus.m_im, bus.m_err} !== 33'd0) begin errors++; $display("FAIL rst_result: got %h want 0", {bus.m_re, bus.m_im, bus.m_err}); end
    checks++; if (bus.mul_a !== 16'h0) begin errors++; $display("FAIL rst_mul_a: got %h want 0000", bus.mul_a); end
    checks++; if (bus.op_count !== 16'h0) begin errors++; $display("FAIL rst_op_count: got %h want 0000", bus.op_count); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_normal;
    logic [15:0] re, im; logic err; int fc, lat;
    do_op(16'h3C00, 16'h0, 16'h3E00, 16'h0, 1'b1, re, im, err, fc, lat);
    checks++; if (re !== 16'h1234) begin errors++; $display("FAIL normal_re: got %h want 1234", re); end
    checks++; if (im !== 16'h5678) begin errors++; $display("FAIL normal_im: got %h want 5678", im); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL normal_err: got %b want 0", err); end
    checks++; if (fc != 5) begin errors++; $display("FAIL normal_flag_cycles: got %0d want 5", fc); end
    checks++; if (lat != 6) begin errors++; $display("FAIL normal_latency: got %0d want 6", lat); end
  endtask

  task automatic test_zero_bypass;
    logic [15:0] re, im; logic err; int fc, lat;
    do_op(16'h0, 16'h0, 16'h3C00, 16'h0, 1'b1, re, im, err, fc, lat);
    checks++; if (fc != 0) begin errors++; $display("FAIL zero_flag_cycles: got %0d want 0", fc); end
    checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
    checks++; if ({re, im, err} !== 33'd0) begin errors++; $display("FAIL zero_result: got %h want 0", {re, im, err}); end
  endtask

  task automatic test_timeout;
    logic [15:0] re, im; logic err; int fc, lat;
    mock_en = 1'b0;
    do_op(16'h3C00, 16'h0, 16'h3E00, 16'h0, 1'b1, re, im, err, fc, lat);
    mock_en = 1'b1;
    checks++; if (fc != 32) begin errors++; $display("FAIL timeout_flag_cycles: got %0d want 32", fc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
    checks++; if ({re, im} !== 32'd0) begin errors++; $display("FAIL timeout_result: got %h want 0", {re, im}); end
  endtask

  task automatic test_backpressure;
    logic [15:0] re, im; logic err; int fc, lat; int bad;
    do_op(16'h3C00, 16'h0, 16'h3E00, 16'h0, 1'b0, re, im, err, fc, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.m_re !== 16'h1234 || bus.m_im !== 16'h5678 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
    bus.m_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.s_ready, bus.m_valid, bus.mul_flag} !== 3'b000) begin errors++; $display("FAIL bp_gap: ready/valid/flag=%b want 000", {bus.s_ready, bus.m_valid, bus.mul_flag}); end
    @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_back_to_back;
    int k_in, k_out, low_run, min_gap; logic seen_high, acc; int acc_cyc[4];
    logic [15:0] exp_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mock_mode = 1'b1;
    k_in = 0; k_out = 0; low_run = 0; min_gap = 999; seen_high = 1'b0;
    acc_cyc = '{0, 0, 0, 0};
    bus.s_a = va[0]; bus.s_a_i = vai[0]; bus.s_b = vb[0]; bus.s_b_i = vbi[0];
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && k_out < 4; cyc++) begin
      if (bus.m_valid) begin
        checks++;
        if ({bus.m_re, bus.m_im, bus.m_err} !== vexp[k_out]) begin
          errors++; $display("FAIL b2b_result%0d: got %h want %h", k_out, {bus.m_re, bus.m_im, bus.m_err}, vexp[k_out]);
        end
        k_out++;
      end
      if (bus.mul_flag) begin
        if (seen_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
        seen_high = 1'b1; low_run = 0;
      end else low_run++;
      acc = bus.s_ready && bus.s_valid;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[k_in] = cyc; k_in++;
        if (k_in < 4) begin
          bus.s_a = va[k_in]; bus.s_a_i = vai[k_in]; bus.s_b = vb[k_in]; bus.s_b_i = vbi[k_in];
        end else bus.s_valid = 1'b0;
      end
      @(negedge clk);
    end
    mock_mode = 1'b0;
    checks++; if (k_out != 4) begin errors++; $display("FAIL b2b_count: got %0d results want 4", k_out); end
    checks++; if (min_gap < 2) begin errors++; $display("FAIL b2b_flag_gap: got %0d want >=2", min_gap); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 8) begin errors++; $display("FAIL b2b_period: got %0d want 8", acc_cyc[1] - acc_cyc[0]); end
`ifdef COM_MUL_SEQ_STATS_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif
    checks++; if (bus.op_count !== exp_cnt) begin errors++; $display("FAIL b2b_op_count: got %0d want %0d", bus.op_count, exp_cnt); end
  endtask

  task automatic test_async_reset;
    logic [15:0] re, im; logic err; int fc, lat, w;
    bus.s_a = 16'h3C00; bus.s_a_i = 16'h0; bus.s_b = 16'h3E00; bus.s_b_i = 16'h0;
    bus.s_valid = 1'b1; bus.m_ready = 1'b1;
    w = 0;
    while (!bus.s_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.mul_flag !== 1'b1) begin errors++; $display("FAIL arst_in_run: mul_flag=%b want 1", bus.mul_flag); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.mul_flag, bus.m_valid, bus.s_ready} !== 3'b000) begin errors++; $display("FAIL arst_async: flag/valid/ready=%b want 000", {bus.mul_flag, bus.m_valid, bus.s_ready}); end
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h3C00, 16'h0, 16'h3E00, 16'h0, 1'b1, re, im, err, fc, lat);
    checks++; if ({re, im, err} !== {16'h1234, 16'h5678, 1'b0}) begin errors++; $display("FAIL arst_fresh_result: got %h want %h", {re, im, err}, {16'h1234, 16'h5678, 1'b0}); end
    checks++; if (fc != 5) begin errors++; $display("FAIL arst_fresh_flag: got %0d want 5", fc); end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    bus.s_a = '0; bus.s_a_i = '0; bus.s_b = '0; bus.s_b_i = '0;
    bus.s_mbit1 = '0; bus.s_mbit2 = '0;
    test_reset();
    test_normal();
    test_zero_bypass();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
